rvc_asap_5pl_lsu: RTL and testbench
===================================

RVC_ASAP_5PL_LSU -- requirements
Module: rvc_asap_5pl_lsu

Interface
REQ-001 Parameters: none; memory geometry SHALL come from rvc_asap_pkg.
REQ-002 Clock  in  1  single core clock; all state SHALL update on its rising edge.
REQ-003 Rst  in  1  reset, synchronous, active-high.
REQ-004 LsuValid  in  1  memory op present in the Q103H stage.
REQ-005 LsuIsLoad / LsuIsStore  in  1 each  op type, mutually exclusive.
REQ-006 LsuFunct3  in  3  size/sign: 0 B, 1 H, 2 W, 4 BU, 5 HU.
REQ-007 LsuAddr  in  32  byte address.
REQ-008 LsuStoreData  in  32  unaligned store value in bits [31:0].
REQ-009 LsuStall  out  1  requester SHALL hold all inputs while high.
REQ-010 DMemAddr  out  32  word-aligned address (bits [1:0] = 0).
REQ-011 DMemWrData / DMemByteEn / DMemWrEn / DMemRdEn  out  32/4/1/1  d_mem request.
REQ-012 DMemRdData  in  32  d_mem read word, valid one cycle after DMemRdEn.
REQ-013 LsuLoadData  out  32  aligned, extended load result.
REQ-014 LsuLoadValid  out  1  one-cycle pulse qualifying LsuLoadData.
REQ-015 LsuMisalign  out  1  one-cycle pulse: misaligned access dropped.

Function
REQ-016 Mask SHALL be an 8-bit value: B=0x01, H=0x03, W=0x0F, shifted left by LsuAddr[1:0].
REQ-017 An access SHALL be misaligned iff mask[7:4] != 0.
REQ-018 Store data SHALL be a 64-bit value: LsuStoreData shifted left by 8*LsuAddr[1:0].
REQ-019 FSM states SHALL be IDLE and SPLIT2 only.
REQ-020 IDLE, aligned valid op: issue DMemAddr={LsuAddr[31:2],2'b0}, DMemByteEn=mask[3:0], WrData=low word; LsuStall=0; stay IDLE.
REQ-021 Aligned load issued in cycle N SHALL produce LsuLoadValid=1 in cycle N+1.
REQ-022 IDLE, misaligned op (split enabled): cycle N issues the low word with mask[3:0], LsuStall=1, next state SPLIT2.
REQ-023 SPLIT2 (cycle N+1): issue address+4, mask[7:4], high store word; LsuStall=0; capture low read word in a holding register; inputs are ignored; next state IDLE.
REQ-024 Split load SHALL assert LsuLoadValid in cycle N+2, using {hi,lo} shifted right by 8*offset.
REQ-025 Load result SHALL be sign-extended for funct3 0/1 and zero-extended for 4/5; W SHALL pass unchanged.
REQ-026 Offset and funct3 for a load SHALL be pipelined to align with the one-cycle read latency.
REQ-027 Illegal funct3 (3, 6, 7, or 4/5 on store) SHALL issue no access and raise no LsuLoadValid or LsuMisalign.
REQ-028 With no valid op, DMemWrEn, DMemRdEn and DMemByteEn SHALL be 0.
REQ-029 Aligned back-to-back ops SHALL sustain one access per cycle with LsuStall=0.

Reset
REQ-030 Rst=1 SHALL force: state IDLE; LsuStall, DMemWrEn, DMemRdEn, DMemByteEn, LsuLoadValid, LsuMisalign = 0; holding and pipeline registers = 0.
REQ-031 Rst asserted in SPLIT2 SHALL abort the second access; no LsuLoadValid follows.

Configuration
REQ-032 Macro RVC_LSU_MISALIGN_SPLIT_EN defined: misaligned ops SHALL split per REQ-022..024.
REQ-033 Macro undefined: misaligned ops SHALL issue no access, LsuStall stays 0, LsuMisalign pulses in the same cycle, SPLIT2 SHALL be unreachable.

Verification
REQ-034 SW 0xAABBCCDD @0x1000, then LW @0x1000 -> ByteEn 0xF; LsuLoadData 0xAABBCCDD one cycle after read.
REQ-035 Word 0x80FF7F01 @0x1000: LB @0x1002 -> 0xFFFFFFFF; LBU @0x1002 -> 0x000000FF; LH @0x1002 -> 0xFFFF80FF.
REQ-036 Split on, LW @0x1003, memory 0x1000=0x44332211, 0x1004=0x88776655 -> ByteEn 0x8 then 0x7, stall one cycle, result 0x77665544 at N+2.
REQ-037 Split on, SH 0x1234 @0x1003 -> cycle N: addr 0x1000, ByteEn 0x8, WrData[31:24]=0x34; N+1: addr 0x1004, ByteEn 0x1, WrData[7:0]=0x12.
REQ-038 Split off, LW @0x1001 -> no DMemRdEn, LsuMisalign=1 for one cycle, LsuLoadValid never asserts.
REQ-039 Rst=1 during SPLIT2 of a split load -> next cycle IDLE, all outputs 0, no load valid.

Source files
------------

// File: rtl/rvc_asap_5pl_lsu_if.sv
// rvc_asap_5pl_lsu_if -- d_mem request/response bus.
//
// Signals:
//   DMemAddr    word-aligned address
//   DMemWrData  write word
//   DMemByteEn  byte enables
//   DMemWrEn    write strobe
//   DMemRdEn    read strobe
//   DMemRdData  read word, valid one cycle after DMemRdEn
// Modports: master (LSU side), slave (memory side).

interface rvc_asap_5pl_lsu_if;
    logic [31:0] DMemAddr;
    logic [31:0] DMemWrData;
    logic [3:0]  DMemByteEn;
    logic        DMemWrEn;
    logic        DMemRdEn;
    logic [31:0] DMemRdData;

    modport master (
        output DMemAddr, DMemWrData, DMemByteEn, DMemWrEn, DMemRdEn,
        input  DMemRdData
    );

    modport slave (
        input  DMemAddr, DMemWrData, DMemByteEn, DMemWrEn, DMemRdEn,
        output DMemRdData
    );
endinterface

// File: rtl/rvc_asap_5pl_lsu.sv
// rvc_asap_5pl_lsu -- load/store unit for the 5-stage rvc_asap core.
//
// Converts a Q103H memory op (byte/half/word, signed/unsigned) into a
// word-aligned d_mem request and realigns/extends the read word one cycle
// later.
//
// Ports:
//   Clock, Rst      core clock, synchronous active-high reset
//   LsuValid        memory op present
//   LsuIsLoad/Store op type
//   LsuFunct3       0 B, 1 H, 2 W, 4 BU, 5 HU
//   LsuAddr         byte address
//   LsuStoreData    store value, unaligned in [31:0]
//   LsuStall        requester must hold inputs while high
//   dmem            d_mem request/response bus (master side)
//   LsuLoadData     aligned, extended load result
//   LsuLoadValid    one-cycle pulse qualifying LsuLoadData
//   LsuMisalign     one-cycle pulse, misaligned access dropped
//
// Build option RVC_LSU_MISALIGN_SPLIT_EN: when defined, accesses crossing a
// word boundary are split into two consecutive d_mem accesses; otherwise they
// are dropped and flagged on LsuMisalign.

package rvc_asap_pkg;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned OFF_W = 2;    // byte offset within a d_mem word
endpackage

module rvc_asap_5pl_lsu
    import rvc_asap_pkg::*;
(
    input  logic               Clock,
    input  logic               Rst,
    input  logic               LsuValid,
    input  logic               LsuIsLoad,
    input  logic               LsuIsStore,
    input  logic [2:0]         LsuFunct3,
    input  logic [XLEN-1:0]    LsuAddr,
    input  logic [XLEN-1:0]    LsuStoreData,
    output logic               LsuStall,
    rvc_asap_5pl_lsu_if.master dmem,
    output logic [XLEN-1:0]    LsuLoadData,
    output logic               LsuLoadValid,
    output logic               LsuMisalign
);

    typedef enum logic [0:0] {IDLE, SPLIT2} state_t;

    state_t           state, next_state;
    logic [3:0]       base_mask;
    logic [7:0]       mask8;
    logic [XLEN-1:0]  st_lo;
    logic             legal, op_ok, misalign;

    // load return pipeline: aligns offset/funct3 with the read latency
    logic             rd_pend;
    logic [OFF_W-1:0] rd_off;
    logic [2:0]       rd_f3;
    logic             issue_rd;
    logic [OFF_W-1:0] issue_off;
    logic [2:0]       issue_f3;
    logic [2*XLEN-1:0] rd_pair;
    logic [XLEN-1:0]  rd_word;

`ifdef RVC_LSU_MISALIGN_SPLIT_EN
    logic [2*XLEN-1:0] st64;
    logic [XLEN-1:0]  st_hi;
    logic [XLEN-3:0]  sp_waddr;
    logic [3:0]       sp_mask;
    logic [XLEN-1:0]  sp_wdata;
    logic             sp_load;
    logic [OFF_W-1:0] sp_off;
    logic [2:0]       sp_f3;
    logic             rd_split, issue_split;
    logic [XLEN-1:0]  lo_hold;
`endif

    always_comb begin
        case (LsuFunct3[1:0])
            2'd0:    base_mask = 4'h1;
            2'd1:    base_mask = 4'h3;
            default: base_mask = 4'hF;
        endcase
    end

    assign mask8    = {4'h0, base_mask} << LsuAddr[1:0];
    assign misalign = |mask8[7:4];

`ifdef RVC_LSU_MISALIGN_SPLIT_EN
    assign st64  = {{XLEN{1'b0}}, LsuStoreData} << {LsuAddr[1:0], 3'b000};
    assign st_lo = st64[XLEN-1:0];
    assign st_hi = st64[2*XLEN-1:XLEN];
`else
    assign st_lo = LsuStoreData << {LsuAddr[1:0], 3'b000};
`endif

    always_comb begin
        case (LsuFunct3)
            3'd0, 3'd1, 3'd2: legal = 1'b1;
            3'd4, 3'd5:       legal = LsuIsLoad;
            default:          legal = 1'b0;
        endcase
    end

    assign op_ok = LsuValid & (LsuIsLoad | LsuIsStore) & legal;

    always_comb begin
        next_state        = state;
        LsuStall          = 1'b0;
        LsuMisalign       = 1'b0;
        dmem.DMemAddr     = '0;
        dmem.DMemWrData   = '0;
        dmem.DMemByteEn   = '0;
        dmem.DMemWrEn     = 1'b0;
        dmem.DMemRdEn     = 1'b0;
        issue_rd          = 1'b0;
        issue_off         = LsuAddr[1:0];
        issue_f3          = LsuFunct3;
`ifdef RVC_LSU_MISALIGN_SPLIT_EN
        issue_split       = 1'b0;
`endif
        if (!Rst) begin
            case (state)
                IDLE: begin
                    if (op_ok) begin
`ifdef RVC_LSU_MISALIGN_SPLIT_EN
                        // low word goes out now for both aligned and split ops
                        dmem.DMemAddr   = {LsuAddr[XLEN-1:2], 2'b00};
                        dmem.DMemByteEn = mask8[3:0];
                        dmem.DMemWrData = st_lo;
                        dmem.DMemWrEn   = LsuIsStore;
                        dmem.DMemRdEn   = LsuIsLoad;
                        if (misalign) begin
                            LsuStall   = 1'b1;
                            next_state = SPLIT2;
                        end else begin
                            issue_rd   = LsuIsLoad;
                        end
`else
                        if (misalign) begin
                            LsuMisalign = 1'b1;
                        end else begin
                            dmem.DMemAddr   = {LsuAddr[XLEN-1:2], 2'b00};
                            dmem.DMemByteEn = mask8[3:0];
                            dmem.DMemWrData = st_lo;
                            dmem.DMemWrEn   = LsuIsStore;
                            dmem.DMemRdEn   = LsuIsLoad;
                            issue_rd        = LsuIsLoad;
                        end
`endif
                    end
                end
`ifdef RVC_LSU_MISALIGN_SPLIT_EN
                SPLIT2: begin
                    dmem.DMemAddr   = {sp_waddr, 2'b00};
                    dmem.DMemByteEn = sp_mask;
                    dmem.DMemWrData = sp_wdata;
                    dmem.DMemWrEn   = ~sp_load;
                    dmem.DMemRdEn   = sp_load;
                    issue_rd        = sp_load;
                    issue_split     = sp_load;
                    issue_off       = sp_off;
                    issue_f3        = sp_f3;
                    next_state      = IDLE;
                end
`endif
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Rst) begin
            state    <= IDLE;
            rd_pend  <= 1'b0;
            rd_off   <= '0;
            rd_f3    <= '0;
`ifdef RVC_LSU_MISALIGN_SPLIT_EN
            rd_split <= 1'b0;
            lo_hold  <= '0;
            sp_waddr <= '0;
            sp_mask  <= '0;
            sp_wdata <= '0;
            sp_load  <= 1'b0;
            sp_off   <= '0;
            sp_f3    <= '0;
`endif
        end else begin
            state    <= next_state;
            rd_pend  <= issue_rd;
            rd_off   <= issue_off;
            rd_f3    <= issue_f3;
`ifdef RVC_LSU_MISALIGN_SPLIT_EN
            rd_split <= issue_split;
            // low read word returns during SPLIT2; keep it for the merge
            if (state == SPLIT2)
                lo_hold <= dmem.DMemRdData;
            if (next_state == SPLIT2) begin
                sp_waddr <= LsuAddr[XLEN-1:2] + 1'b1;
                sp_mask  <= mask8[7:4];
                sp_wdata <= st_hi;
                sp_load  <= LsuIsLoad;
                sp_off   <= LsuAddr[1:0];
                sp_f3    <= LsuFunct3;
            end
`endif
        end
    end

`ifdef RVC_LSU_MISALIGN_SPLIT_EN
    assign rd_pair = rd_split ? {dmem.DMemRdData, lo_hold} : {{XLEN{1'b0}}, dmem.DMemRdData};
`else
    assign rd_pair = {{XLEN{1'b0}}, dmem.DMemRdData};
`endif
    assign rd_word = XLEN'(rd_pair >> {rd_off, 3'b000});

    always_comb begin
        case (rd_f3)
            3'd0:    LsuLoadData = {{24{rd_word[7]}}, rd_word[7:0]};
            3'd1:    LsuLoadData = {{16{rd_word[15]}}, rd_word[15:0]};
            3'd4:    LsuLoadData = {24'h0, rd_word[7:0]};
            3'd5:    LsuLoadData = {16'h0, rd_word[15:0]};
            default: LsuLoadData = rd_word;
        endcase
    end

    assign LsuLoadValid = rd_pend & ~Rst;

endmodule

// File: tb/tb_rvc_asap_5pl_lsu.sv
module tb_rvc_asap_5pl_lsu;

    logic        Clock = 1'b0;
    logic        Rst;
    logic        LsuValid, LsuIsLoad, LsuIsStore;
    logic [2:0]  LsuFunct3;
    logic [31:0] LsuAddr, LsuStoreData;
    logic        LsuStall, LsuLoadValid, LsuMisalign;
    logic [31:0] LsuLoadData;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [16];

    always #5 Clock = ~Clock;

    rvc_asap_5pl_lsu_if bus();

    rvc_asap_5pl_lsu dut (
        .Clock        (Clock),
        .Rst          (Rst),
        .LsuValid     (LsuValid),
        .LsuIsLoad    (LsuIsLoad),
        .LsuIsStore   (LsuIsStore),
        .LsuFunct3    (LsuFunct3),
        .LsuAddr      (LsuAddr),
        .LsuStoreData (LsuStoreData),
        .LsuStall     (LsuStall),
        .dmem         (bus.master),
        .LsuLoadData  (LsuLoadData),
        .LsuLoadValid (LsuLoadValid),
        .LsuMisalign  (LsuMisalign)
    );

    // d_mem: byte-enabled writes, one-cycle registered reads
    always @(posedge Clock) begin
        if (bus.DMemWrEn)
            for (int b = 0; b < 4; b++)
                if (bus.DMemByteEn[b])
                    mem[bus.DMemAddr[5:2]][8*b +: 8] <= bus.DMemWrData[8*b +: 8];
        if (bus.DMemRdEn)
            bus.DMemRdData <= mem[bus.DMemAddr[5:2]];
    end

    task automatic op(input logic ld, input logic st, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d);
        LsuValid = 1'b1; LsuIsLoad = ld; LsuIsStore = st;
        LsuFunct3 = f3; LsuAddr = a; LsuStoreData = d;
    endtask

    task automatic nop();
        LsuValid = 1'b0; LsuIsLoad = 1'b0; LsuIsStore = 1'b0;
        LsuFunct3 = 3'd0; LsuAddr = 32'h0; LsuStoreData = 32'h0;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic mid();
        @(negedge Clock);
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        tick(); op(1'b1, 1'b0, 3'd2, 32'h1000, 32'h0); mid();
        checks++; if (LsuStall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%h exp=0", LsuStall); end
        checks++; if (bus.DMemRdEn !== 1'b0) begin failures++; $display("FAIL rst_rden got=%h exp=0", bus.DMemRdEn); end
        checks++; if (bus.DMemWrEn !== 1'b0) begin failures++; $display("FAIL rst_wren got=%h exp=0", bus.DMemWrEn); end
        checks++; if (bus.DMemByteEn !== 4'h0) begin failures++; $display("FAIL rst_byteen got=%h exp=0", bus.DMemByteEn); end
        checks++; if (LsuMisalign !== 1'b0) begin failures++; $display("FAIL rst_misalign got=%h exp=0", LsuMisalign); end
        tick(); mid();
        checks++; if (LsuLoadValid !== 1'b0) begin failures++; $display("FAIL rst_loadvalid got=%h exp=0", LsuLoadValid); end
        tick(); Rst = 1'b0; nop(); mid();
        checks++; if (LsuLoadValid !== 1'b0) begin failures++; $display("FAIL rst_exit_loadvalid got=%h exp=0", LsuLoadValid); end
    endtask

    task automatic test_sw_lw();
        tick(); op(1'b0, 1'b1, 3'd2, 32'h1000, 32'hAABBCCDD); mid();
        checks++; if (bus.DMemWrEn !== 1'b1) begin failures++; $display("FAIL sw_wren got=%h exp=1", bus.DMemWrEn); end
        checks++; if (bus.DMemByteEn !== 4'hF) begin failures++; $display("FAIL sw_byteen got=%h exp=f", bus.DMemByteEn); end
        checks++; if (bus.DMemAddr !== 32'h1000) begin failures++; $display("FAIL sw_addr got=%h exp=00001000", bus.DMemAddr); end
        checks++; if (bus.DMemWrData !== 32'hAABBCCDD) begin failures++; $display("FAIL sw_wrdata got=%h exp=aabbccdd", bus.DMemWrData); end
        checks++; if (LsuStall !== 1'b0) begin failures++; $display("FAIL sw_stall got=%h exp=0", LsuStall); end
        tick(); op(1'b1, 1'b0, 3'd2, 32'h1000, 32'h0); mid();
        checks++; if (bus.DMemRdEn !== 1'b1) begin failures++; $display("FAIL lw_rden got=%h exp=1", bus.DMemRdEn); end
        checks++; if (bus.DMemByteEn !== 4'hF) begin failures++; $display("FAIL lw_byteen got=%h exp=f", bus.DMemByteEn); end
        checks++; if (LsuLoadValid !== 1'b0) begin failures++; $display("FAIL lw_early_valid got=%h exp=0", LsuLoadValid); end
        tick(); nop(); mid();
        checks++; if (LsuLoadValid !== 1'b1) begin failures++; $display("FAIL lw_valid got=%h exp=1", LsuLoadValid); end
        checks++; if (LsuLoadData !== 32'hAABBCCDD) begin failures++; $display("FAIL lw_data got=%h exp=aabbccdd", LsuLoadData); end
        checks++; if (bus.DMemRdEn !== 1'b0) begin failures++; $display("FAIL idle_rden got=%h exp=0", bus.DMemRdEn); end
        checks++; if (bus.DMemByteEn !== 4'h0) begin failures++; $display("FAIL idle_byteen got=%h exp=0", bus.DMemByteEn); end
        checks++; if (bus.DMemWrEn !== 1'b0) begin failures++; $display("FAIL idle_wren got=%h exp=0", bus.DMemWrEn); end
        tick(); mid();
        checks++; if (LsuLoadValid !== 1'b0) begin failures++; $display("FAIL lw_pulse got=%h exp=0", LsuLoadValid); end
    endtask

    task automatic test_back_to_back();
        tick(); op(1'b0, 1'b1, 3'd2, 32'h1000, 32'h80FF7F01); mid();
        tick(); op(1'b1, 1'b0, 3'd0, 32'h1002, 32'h0); mid();
        checks++; if (LsuStall !== 1'b0) begin failures++; $display("FAIL lb_stall got=%h exp=0", LsuStall); end
        checks++; if (bus.DMemByteEn !== 4'h4) begin failures++; $display("FAIL lb_byteen got=%h exp=4", bus.DMemByteEn); end
        tick(); op(1'b1, 1'b0, 3'd4, 32'h1002, 32'h0); mid();
        checks++; if (LsuLoadValid !== 1'b1) begin failures++; $display("FAIL lb_valid got=%h exp=1", LsuLoadValid); end
        checks++; if (LsuLoadData !== 32'hFFFFFFFF) begin failures++; $display("FAIL lb_data got=%h exp=ffffffff", LsuLoadData); end
        checks++; if (bus.DMemRdEn !== 1'b1) begin failures++; $display("FAIL lbu_rden got=%h exp=1", bus.DMemRdEn); end
        tick(); op(1'b1, 1'b0, 3'd1, 32'h1002, 32'h0); mid();
        checks++; if (LsuLoadData !== 32'h000000FF) begin failures++; $display("FAIL lbu_data got=%h exp=000000ff", LsuLoadData); end
        checks++; if (bus.DMemByteEn !== 4'hC) begin failures++; $display("FAIL lh_byteen got=%h exp=c", bus.DMemByteEn); end
        checks++; if (LsuStall !== 1'b0) begin failures++; $display("FAIL lh_stall got=%h exp=0", LsuStall); end
        tick(); op(1'b1, 1'b0, 3'd5, 32'h1002, 32'h0); mid();
        checks++; if (LsuLoadData !== 32'hFFFF80FF) begin failures++; $display("FAIL lh_data got=%h exp=ffff80ff", LsuLoadData); end
        tick(); op(1'b0, 1'b1, 3'd0, 32'h1001, 32'h0000005A); mid();
        checks++; if (LsuLoadValid !== 1'b1) begin failures++; $display("FAIL lhu_valid got=%h exp=1", LsuLoadValid); end
        checks++; if (LsuLoadData !== 32'h000080FF) begin failures++; $display("FAIL lhu_data got=%h exp=000080ff", LsuLoadData); end
        checks++; if (bus.DMemByteEn !== 4'h2) begin failures++; $display("FAIL sb_byteen got=%h exp=2", bus.DMemByteEn); end
        checks++; if (bus.DMemWrData !== 32'h00005A00) begin failures++; $display("FAIL sb_wrdata got=%h exp=00005a00", bus.DMemWrData); end
        tick(); op(1'b1, 1'b0, 3'd2, 32'h1000, 32'h0); mid();
        checks++; if (LsuLoadValid !== 1'b0) begin failures++; $display("FAIL sb_novalid got=%h exp=0", LsuLoadValid); end
        tick(); nop(); mid();
        checks++; if (LsuLoadData !== 32'h80FF5A01) begin failures++; $display("FAIL sb_readback got=%h exp=80ff5a01", LsuLoadData); end
    endtask

    task automatic test_illegal();
        tick(); op(1'b1, 1'b0, 3'd3, 32'h1000, 32'h0); mid();
        checks++; if (bus.DMemRdEn !== 1'b0) begin failures++; $display("FAIL ill3_rden got=%h exp=0", bus.DMemRdEn); end
        checks++; if (bus.DMemByteEn !== 4'h0) begin failures++; $display("FAIL ill3_byteen got=%h exp=0", bus.DMemByteEn); end
        checks++; if (LsuMisalign !== 1'b0) begin failures++; $display("FAIL ill3_misalign got=%h exp=0", LsuMisalign); end
        tick(); op(1'b0, 1'b1, 3'd4, 32'h1000, 32'h12345678); mid();
        checks++; if (LsuLoadValid !== 1'b0) begin failures++; $display("FAIL ill3_valid got=%h exp=0", LsuLoadValid); end
        checks++; if (bus.DMemWrEn !== 1'b0) begin failures++; $display("FAIL illsbu_wren got=%h exp=0", bus.DMemWrEn); end
        tick(); op(1'b1, 1'b0, 3'd7, 32'h1000, 32'h0); mid();
        checks++; if (bus.DMemRdEn !== 1'b0) begin failures++; $display("FAIL ill7_rden got=%h exp=0", bus.DMemRdEn); end
        tick(); op(1'b1, 1'b0, 3'd2, 32'h1000, 32'h0); mid();
        checks++; if (LsuLoadValid !== 1'b0) begin failures++; $display("FAIL ill7_valid got=%h exp=0", LsuLoadValid); end
        tick(); nop(); mid();
        checks++; if (LsuLoadData !== 32'h80FF5A01) begin failures++; $display("FAIL ill_mem_intact got=%h exp=80ff5a01", LsuLoadData); end
    endtask

`ifdef RVC_LSU_MISALIGN_SPLIT_EN
    task automatic test_split();
        tick(); op(1'b0, 1'b1, 3'd2, 32'h1000, 32'h44332211); mid();
        tick(); op(1'b0, 1'b1, 3'd2, 32'h1004, 32'h88776655); mid();
        tick(); op(1'b1, 1'b0, 3'd2, 32'h1003, 32'h0); mid();
        checks++; if (bus.DMemAddr !== 32'h1000) begin failures++; $display("FAIL splw_addr0 got=%h exp=00001000", bus.DMemAddr); end
        checks++; if (bus.DMemByteEn !== 4'h8) begin failures++; $display("FAIL splw_be0 got=%h exp=8", bus.DMemByteEn); end
        checks++; if (LsuStall !== 1'b1) begin failures++; $display("FAIL splw_stall0 got=%h exp=1", LsuStall); end
        tick(); mid();
        checks++; if (bus.DMemAddr !== 32'h1004) begin failures++; $display("FAIL splw_addr1 got=%h exp=00001004", bus.DMemAddr); end
        checks++; if (bus.DMemByteEn !== 4'h7) begin failures++; $display("FAIL splw_be1 got=%h exp=7", bus.DMemByteEn); end
        checks++; if (LsuStall !== 1'b0) begin failures++; $display("FAIL splw_stall1 got=%h exp=0", LsuStall); end
        checks++; if (LsuLoadValid !== 1'b0) begin failures++; $display("FAIL splw_early got=%h exp=0", LsuLoadValid); end
        tick(); nop(); mid();
        checks++; if (LsuLoadValid !== 1'b1) begin failures++; $display("FAIL splw_valid got=%h exp=1", LsuLoadValid); end
        checks++; if (LsuLoadData !== 32'h77665544) begin failures++; $display("FAIL splw_data got=%h exp=77665544", LsuLoadData); end
        tick(); op(1'b0, 1'b1, 3'd1, 32'h1003, 32'h00001234); mid();
        checks++; if (bus.DMemAddr !== 32'h1000) begin failures++; $display("FAIL splsh_addr0 got=%h exp=00001000", bus.DMemAddr); end
        checks++; if (bus.DMemByteEn !== 4'h8) begin failures++; $display("FAIL splsh_be0 got=%h exp=8", bus.DMemByteEn); end
        checks++; if (bus.DMemWrData[31:24] !== 8'h34) begin failures++; $display("FAIL splsh_wd0 got=%h exp=34", bus.DMemWrData[31:24]); end
        tick(); mid();
        checks++; if (bus.DMemAddr !== 32'h1004) begin failures++; $display("FAIL splsh_addr1 got=%h exp=00001004", bus.DMemAddr); end
        checks++; if (bus.DMemByteEn !== 4'h1) begin failures++; $display("FAIL splsh_be1 got=%h exp=1", bus.DMemByteEn); end
        checks++; if (bus.DMemWrData[7:0] !== 8'h12) begin failures++; $display("FAIL splsh_wd1 got=%h exp=12", bus.DMemWrData[7:0]); end
        tick(); op(1'b1, 1'b0, 3'd2, 32'h1000, 32'h0); mid();
        tick(); op(1'b1, 1'b0, 3'd2, 32'h1004, 32'h0); mid();
        checks++; if (LsuLoadData !== 32'h34332211) begin failures++; $display("FAIL splsh_lo got=%h exp=34332211", LsuLoadData); end
        tick(); nop(); mid();
        checks++; if (LsuLoadData !== 32'h88776612) begin failures++; $display("FAIL splsh_hi got=%h exp=88776612", LsuLoadData); end
        // reset while the second half of a split load is outstanding
        tick(); op(1'b1, 1'b0, 3'd2, 32'h1003, 32'h0); mid();
        tick(); Rst = 1'b1; mid();
        checks++; if (bus.DMemRdEn !== 1'b0) begin failures++; $display("FAIL splrst_rden got=%h exp=0", bus.DMemRdEn); end
        checks++; if (bus.DMemByteEn !== 4'h0) begin failures++; $display("FAIL splrst_be got=%h exp=0", bus.DMemByteEn); end
        tick(); Rst = 1'b0; nop(); mid();
        checks++; if (LsuLoadValid !== 1'b0) begin failures++; $display("FAIL splrst_valid got=%h exp=0", LsuLoadValid); end
        checks++; if (LsuStall !== 1'b0) begin failures++; $display("FAIL splrst_stall got=%h exp=0", LsuStall); end
        tick(); op(1'b1, 1'b0, 3'd2, 32'h1000, 32'h0); mid();
        checks++; if (bus.DMemAddr !== 32'h1000) begin failures++; $display("FAIL splrst_idle_addr got=%h exp=00001000", bus.DMemAddr); end
        checks++; if (LsuStall !== 1'b0) begin failures++; $display("FAIL splrst_idle_stall got=%h exp=0", LsuStall); end
        tick(); nop(); mid();
        checks++; if (LsuLoadData !== 32'h34332211) begin failures++; $display("FAIL splrst_idle_data got=%h exp=34332211", LsuLoadData); end
    endtask
`else
    task automatic test_misalign_drop();
        tick(); op(1'b1, 1'b0, 3'd2, 32'h1001, 32'h0); mid();
        checks++; if (bus.DMemRdEn !== 1'b0) begin failures++; $display("FAIL mis_rden got=%h exp=0", bus.DMemRdEn); end
        checks++; if (LsuMisalign !== 1'b1) begin failures++; $display("FAIL mis_flag got=%h exp=1", LsuMisalign); end
        checks++; if (LsuStall !== 1'b0) begin failures++; $display("FAIL mis_stall got=%h exp=0", LsuStall); end
        checks++; if (bus.DMemByteEn !== 4'h0) begin failures++; $display("FAIL mis_byteen got=%h exp=0", bus.DMemByteEn); end
        tick(); nop(); mid();
        checks++; if (LsuMisalign !== 1'b0) begin failures++; $display("FAIL mis_pulse got=%h exp=0", LsuMisalign); end
        checks++; if (LsuLoadValid !== 1'b0) begin failures++; $display("FAIL mis_novalid got=%h exp=0", LsuLoadValid); end
        tick(); op(1'b0, 1'b1, 3'd2, 32'h1002, 32'hDEADBEEF); mid();
        checks++; if (bus.DMemWrEn !== 1'b0) begin failures++; $display("FAIL missw_wren got=%h exp=0", bus.DMemWrEn); end
        checks++; if (LsuMisalign !== 1'b1) begin failures++; $display("FAIL missw_flag got=%h exp=1", LsuMisalign); end
        tick(); op(1'b1, 1'b0, 3'd1, 32'h1003, 32'h0); mid();
        checks++; if (LsuMisalign !== 1'b1) begin failures++; $display("FAIL mislh_flag got=%h exp=1", LsuMisalign); end
        checks++; if (bus.DMemRdEn !== 1'b0) begin failures++; $display("FAIL mislh_rden got=%h exp=0", bus.DMemRdEn); end
        tick(); op(1'b1, 1'b0, 3'd2, 32'h1000, 32'h0); mid();
        checks++; if (LsuMisalign !== 1'b0) begin failures++; $display("FAIL mis_aligned_flag got=%h exp=0", LsuMisalign); end
        checks++; if (LsuLoadValid !== 1'b0) begin failures++; $display("FAIL mislh_novalid got=%h exp=0", LsuLoadValid); end
        tick(); nop(); mid();
        checks++; if (LsuLoadValid !== 1'b1) begin failures++; $display("FAIL mis_readback_valid got=%h exp=1", LsuLoadValid); end
        checks++; if (LsuLoadData !== 32'h80FF5A01) begin failures++; $display("FAIL mis_readback got=%h exp=80ff5a01", LsuLoadData); end
    endtask
`endif

    initial begin
        nop();
        test_reset();
        test_sw_lw();
        test_back_to_back();
        test_illegal();
`ifdef RVC_LSU_MISALIGN_SPLIT_EN
        test_split();
`else
        test_misalign_drop();
`endif
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
